// File: rtl/mac_pkg.sv
// Shared definitions for the MAC array controller: FSM encoding and default widths/latencies.
package mac_pkg;

  localparam int MAC_LAT_DEF = 3;
  localparam int LEN_W_DEF   = 16;
  localparam int DOT_W       = 16;
  localparam int DRAIN_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_ACCUM  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_RESULT = 3'd4
  } state_t;

endpackage

// File: rtl/mac_array_ctrl.sv
// Sequences one MAC-array job: clear, stream len operand beats, wait out the
// array latency, then hand the captured dot product over a valid/ready port.
module mac_array_ctrl
  import mac_pkg::*;
#(
  parameter int MAC_LAT = MAC_LAT_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [15:0]      bias_cfg,
  input  logic             abort,
  output logic             busy,
  output logic             err,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [63:0]      s_data0,
  input  logic [63:0]      s_data1,
  input  logic [63:0]      s_data2,
  input  logic [63:0]      s_data3,
  output logic [63:0]      mac_ch0,
  output logic [63:0]      mac_ch1,
  output logic [63:0]      mac_ch2,
  output logic [63:0]      mac_ch3,
  output logic             mac_en,
  output logic             mac_clr,
  output logic             mac_read_en,
  output logic [15:0]      mac_bias,
  input  logic [DOT_W-1:0] mac_dot,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [DOT_W-1:0] res_data,
  output logic [2:0]       o_dbg_state
);

  state_t             r_state;
  state_t             w_next;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_beat_cnt;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic [15:0]        r_bias;
  logic [DOT_W-1:0]   r_res_data;
  logic               r_err;
  logic               w_accept;
  logic               w_reject;
  logic               w_abort;
  logic               w_last_beat;
  logic               w_drain_done;

  assign w_accept     = (r_state == ST_IDLE) && start && (len != '0);
  assign w_reject     = (r_state == ST_IDLE) && start && (len == '0);
  assign w_abort      = (r_state != ST_IDLE) && abort;
  assign w_last_beat  = (r_beat_cnt + LEN_W'(1)) == r_len;
  assign w_drain_done = r_drain_cnt == DRAIN_W'(1);

  assign busy        = r_state != ST_IDLE;
  assign err         = r_err;
  assign mac_bias    = busy ? r_bias : 16'h0;
  assign res_data    = r_res_data;
  assign o_dbg_state = r_state;
  assign mac_ch0     = (r_state == ST_ACCUM) ? s_data0 : 64'h0;
  assign mac_ch1     = (r_state == ST_ACCUM) ? s_data1 : 64'h0;
  assign mac_ch2     = (r_state == ST_ACCUM) ? s_data2 : 64'h0;
  assign mac_ch3     = (r_state == ST_ACCUM) ? s_data3 : 64'h0;

  // Handshakes: a beat moves on any cycle with s_valid & s_ready, a result on
  // res_valid & res_ready; neither side may make valid wait on ready.
  always_comb begin
    w_next      = r_state;
    s_ready     = 1'b0;
    mac_en      = 1'b0;
    mac_clr     = 1'b0;
    mac_read_en = 1'b0;
    res_valid   = 1'b0;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next = ST_CLEAR;
      ST_CLEAR: begin
        mac_clr = 1'b1;
        w_next  = ST_ACCUM;
      end
      ST_ACCUM: begin
        s_ready = 1'b1;
        mac_en  = s_valid;
        if (s_valid && w_last_beat) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        mac_read_en = 1'b1;
        if (w_drain_done) w_next = ST_RESULT;
      end
      ST_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) w_next = ST_IDLE;
      end
      default:   w_next = ST_IDLE;
    endcase
    // Abort wins everything: wipe the array once and drop any pending result.
    if (w_abort) begin
      w_next      = ST_IDLE;
      mac_clr     = 1'b1;
      s_ready     = 1'b0;
      mac_en      = 1'b0;
      mac_read_en = 1'b0;
      res_valid   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_beat_cnt  <= '0;
      r_drain_cnt <= '0;
      r_bias      <= '0;
      r_res_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_reject;
      if (w_accept) begin
        r_len      <= len;
        r_bias     <= bias_cfg;
        r_beat_cnt <= '0;
      end
      if (mac_en) begin
        r_beat_cnt <= r_beat_cnt + LEN_W'(1);
        if (w_last_beat) r_drain_cnt <= DRAIN_W'(MAC_LAT);
      end
      if ((r_state == ST_DRAIN) && !w_abort) begin
        r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
        if (w_drain_done) r_res_data <= mac_dot;
      end
    end
  end

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Directed bench for mac_array_ctrl: per-cycle expected timeline built from the job rules.
module tb_mac_array_ctrl;
  import mac_pkg::*;

  localparam int LAT = 3;
  localparam int LW  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic [15:0]   bias_cfg = '0;
  logic          abort = 1'b0;
  logic          s_valid = 1'b0;
  logic [63:0]   s_data0 = '0, s_data1 = '0, s_data2 = '0, s_data3 = '0;
  logic [15:0]   mac_dot = '0;
  logic          res_ready = 1'b0;
  logic          busy, err, s_ready, mac_en, mac_clr, mac_read_en, res_valid;
  logic [63:0]   mac_ch0, mac_ch1, mac_ch2, mac_ch3;
  logic [15:0]   mac_bias, res_data;
  logic [2:0]    o_dbg_state;

  mac_array_ctrl #(.MAC_LAT(LAT), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .bias_cfg(bias_cfg),
    .abort(abort), .busy(busy), .err(err), .s_valid(s_valid), .s_ready(s_ready),
    .s_data0(s_data0), .s_data1(s_data1), .s_data2(s_data2), .s_data3(s_data3),
    .mac_ch0(mac_ch0), .mac_ch1(mac_ch1), .mac_ch2(mac_ch2), .mac_ch3(mac_ch3),
    .mac_en(mac_en), .mac_clr(mac_clr), .mac_read_en(mac_read_en),
    .mac_bias(mac_bias), .mac_dot(mac_dot), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        busy, err, rdy, en, clr, rd, rv, acc;
    logic [15:0] bias;
    logic [15:0] res;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc_no = 0;
  bit   pend_err = 1'b0;
  int   cnt_en, cnt_clr, cnt_rd, cnt_rv, cnt_err, cnt_busy;

  function automatic exp_t mk(input logic b_busy, b_clr, b_rdy, b_en, b_rd, b_rv, b_acc,
                              input logic [15:0] b_bias, b_res);
    exp_t e;
    e      = '0;
    e.busy = b_busy;
    e.clr  = b_clr;
    e.rdy  = b_rdy;
    e.en   = b_en;
    e.rd   = b_rd;
    e.rv   = b_rv;
    e.acc  = b_acc;
    e.bias = b_bias;
    e.res  = b_res;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_counts();
    cnt_en = 0; cnt_clr = 0; cnt_rd = 0; cnt_rv = 0; cnt_err = 0; cnt_busy = 0;
  endtask

  exp_t        c_e;
  logic        c_ch_ok;
  logic [63:0] c_act, c_exp;

  always @(negedge clk) begin
    if (!rst) begin
      cyc_no++;
      if (mac_en)    cnt_en++;
      if (mac_clr)   cnt_clr++;
      if (mac_read_en) cnt_rd++;
      if (res_valid) cnt_rv++;
      if (err)       cnt_err++;
      if (busy)      cnt_busy++;
    end
    if (exp_q.size() > 0) begin
      c_e = exp_q.pop_front();
      if (c_e.acc)
        c_ch_ok = (mac_ch0 == s_data0) && (mac_ch1 == s_data1) &&
                  (mac_ch2 == s_data2) && (mac_ch3 == s_data3);
      else
        c_ch_ok = (mac_ch0 == 64'h0) && (mac_ch1 == 64'h0) &&
                  (mac_ch2 == 64'h0) && (mac_ch3 == 64'h0);
      c_act = {24'd0, busy, err, s_ready, mac_en, mac_clr, mac_read_en, res_valid,
               mac_bias, (c_e.rv ? res_data : 16'h0), c_ch_ok};
      c_exp = {24'd0, c_e.busy, c_e.err, c_e.rdy, c_e.en, c_e.clr, c_e.rd, c_e.rv,
               c_e.bias, (c_e.rv ? c_e.res : 16'h0), 1'b1};
      check($sformatf("cycle_%0d", cyc_no), c_act, c_exp);
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs are already applied for this cycle; queue what the outputs must be, then advance.
  task automatic cyc(input exp_t e);
    e.err    = pend_err;
    pend_err = start && (len == '0) && !e.busy;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(mk(0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0));
  endtask

  // vmode 0: s_valid always high; 1: alternates 1,0,1,...
  // abort_at >= 0: abort once that many beats have transferred.
  task automatic run_job(input int n, input logic [15:0] b, input int vmode,
                         input int abort_at, input int hold, input bit start_in_res,
                         input logic [63:0] pat, input logic [15:0] dot_fix);
    int          beats;
    int          ph;
    logic [15:0] dot;
    beats = 0;
    ph    = 0;
    dot   = 16'h0;
    start = 1'b1; len = LW'(n); bias_cfg = b;
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0));
    start = 1'b0; bias_cfg = 16'hDEAD;
    cyc(mk(1, 1, 0, 0, 0, 0, 0, b, 16'h0));
    while (beats < n) begin
      if (abort_at >= 0 && beats == abort_at) begin
        abort = 1'b1; s_valid = 1'b0;
        cyc(mk(1, 1, 0, 0, 0, 0, 1, b, 16'h0));
        abort = 1'b0;
        return;
      end
      s_valid = (vmode == 0) ? 1'b1 : ((ph % 2) == 0);
      ph++;
      if (pat != 64'h0) begin
        s_data0 = pat; s_data1 = pat; s_data2 = pat; s_data3 = pat;
      end else begin
        s_data0 = {$urandom(), $urandom()}; s_data1 = {$urandom(), $urandom()};
        s_data2 = {$urandom(), $urandom()}; s_data3 = {$urandom(), $urandom()};
      end
      cyc(mk(1, 0, 1, s_valid, 0, 0, 1, b, 16'h0));
      if (s_valid) beats++;
    end
    s_valid = 1'b0;
    for (int d = 1; d <= LAT; d++) begin
      mac_dot = (dot_fix != 16'h0) ? dot_fix : 16'($urandom_range(0, 65535));
      if (d == LAT) dot = mac_dot;
      cyc(mk(1, 0, 0, 0, 1, 0, 0, b, 16'h0));
    end
    mac_dot   = 16'h0;
    res_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      start = start_in_res; len = '0;
      cyc(mk(1, 0, 0, 0, 0, 1, 0, b, dot));
      start = 1'b0;
    end
    res_ready = 1'b1;
    cyc(mk(1, 0, 0, 0, 0, 1, 0, b, dot));
    res_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {busy, err, s_ready, mac_en, mac_clr, mac_read_en, res_valid,
                 res_data, mac_bias, (|mac_ch0) | (|mac_ch1) | (|mac_ch2) | (|mac_ch3)},
          64'h0);
    check({name, "_state"}, {61'd0, o_dbg_state}, {61'd0, 3'(ST_IDLE)});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clr_counts();
    #1;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(2);

    // Test 1: len=4, steady stream
    clr_counts();
    run_job(4, 16'h0010, 0, -1, 0, 1'b0, 64'h5555_5555_5555_5555, 16'hBEEF);
    check("t1_mac_en_count", 64'(cnt_en), 64'd4);
    check("t1_clr_count", 64'(cnt_clr), 64'd1);
    check("t1_drain_count", 64'(cnt_rd), 64'd3);
    check("t1_res_data_held", {48'd0, res_data}, 64'hBEEF);
    idle_cycles(1);

    // Test 2: len=3, s_valid 1-0-1-0-1
    clr_counts();
    run_job(3, 16'h00A5, 1, -1, 0, 1'b0, 64'h0, 16'h0);
    check("t2_mac_en_count", 64'(cnt_en), 64'd3);
    check("t2_rv_count", 64'(cnt_rv), 64'd1);

    // Test 3: len=0 rejected
    clr_counts();
    start = 1'b1; len = '0; bias_cfg = 16'h1111;
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0));
    start = 1'b0;
    idle_cycles(3);
    check("t3_err_count", 64'(cnt_err), 64'd1);
    check("t3_busy_count", 64'(cnt_busy), 64'd0);
    check("t3_clr_count", 64'(cnt_clr), 64'd0);

    // Test 4: abort after beat 2 of len=8, then a clean job
    clr_counts();
    run_job(8, 16'h0C0C, 0, 2, 0, 1'b0, 64'h0, 16'h0);
    idle_cycles(1);
    check("t4_clr_count", 64'(cnt_clr), 64'd2);
    check("t4_rv_count", 64'(cnt_rv), 64'd0);
    check("t4_mac_en_count", 64'(cnt_en), 64'd2);
    clr_counts();
    run_job(2, 16'h4242, 0, -1, 0, 1'b0, 64'h0, 16'h0);
    check("t4_next_rv_count", 64'(cnt_rv), 64'd1);

    // Test 5: res_ready low 5 cycles, start (len=0) pulsed meanwhile
    clr_counts();
    run_job(2, 16'h7777, 0, -1, 5, 1'b1, 64'h0, 16'h0);
    idle_cycles(2);
    check("t5_rv_count", 64'(cnt_rv), 64'd6);
    check("t5_err_count", 64'(cnt_err), 64'd0);

    // Boundary: single-beat job
    clr_counts();
    run_job(1, 16'hFFFF, 0, -1, 1, 1'b0, 64'h0, 16'h0);
    check("len1_mac_en_count", 64'(cnt_en), 64'd1);

    // Test 6: async reset mid-ACCUM, then the next job starts with CLEAR
    start = 1'b1; len = LW'(8); bias_cfg = 16'h1234;
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0));
    start = 1'b0;
    cyc(mk(1, 1, 0, 0, 0, 0, 0, 16'h1234, 16'h0));
    s_valid = 1'b1; s_data0 = 64'h1; s_data1 = 64'h2; s_data2 = 64'h3; s_data3 = 64'h4;
    cyc(mk(1, 0, 1, 1, 0, 0, 1, 16'h1234, 16'h0));
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_async_reset");
    s_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    pend_err = 1'b0;
    clr_counts();
    run_job(4, 16'h5A5A, 0, -1, 0, 1'b0, 64'h0, 16'h0);
    check("t6_clr_count", 64'(cnt_clr), 64'd1);
    check("t6_rv_count", 64'(cnt_rv), 64'd1);
    idle_cycles(2);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mac_array_ctrl.md
MAC_ARRAY_CTRL -- requirements
Module: mac_array_ctrl

Interface
REQ-001 Parameter: MAC_LAT, 3, cycles from last accepted beat to valid mac_dot (range 1..15).
REQ-002 Parameter: LEN_W, 16, width of the beat-count field.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  job request; sampled only in IDLE.
REQ-006 len  input  LEN_W  number of 4x64-bit beats in the job.
REQ-007 bias_cfg  input  16  bias for the job; latched with start.
REQ-008 abort  input  1  cancels the current job.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 err  output  1  one-cycle pulse on a rejected start (len==0).
REQ-011 s_valid / s_ready  input / output  1 / 1  operand stream handshake.
REQ-012 s_data0..s_data3  input  64 each  operand beat, one word per DMA channel.
REQ-013 mac_ch0..mac_ch3  output  64 each  to MAC_array DMA_channel_0..3.
REQ-014 mac_en, mac_clr, mac_read_en  output  1 each  MAC_array controls.
REQ-015 mac_bias  output  16  to MAC_array bias.
REQ-016 mac_dot  input  16  MAC_array dot_product.
REQ-017 res_valid / res_ready  output / input  1 / 1  result handshake.
REQ-018 res_data  output  16  captured dot product.

Function
REQ-019 FSM states SHALL be IDLE, CLEAR, ACCUM, DRAIN, RESULT.
REQ-020 IDLE: start=1 and len!=0 -> latch len and bias_cfg, go CLEAR; start=1 and len==0 -> err pulse next cycle, stay IDLE.
REQ-021 CLEAR: mac_clr=1 for exactly one cycle, mac_en=0; next state ACCUM.
REQ-022 ACCUM: s_ready=1; a beat transfers when s_valid&s_ready; mac_en=s_valid&s_ready (combinational, same cycle).
REQ-023 mac_chN SHALL equal s_dataN combinationally in ACCUM, and SHALL be zero in all other states.
REQ-024 A beat counter SHALL increment per transfer; on transfer of beat len it SHALL go to DRAIN and load the drain counter with MAC_LAT.
REQ-025 s_valid low in ACCUM SHALL stall without time-out; mac_en=0 during stall cycles.
REQ-026 s_ready SHALL be 0 in every state other than ACCUM.
REQ-027 DRAIN: mac_read_en=1; the drain counter decrements each cycle; at count 1, res_data<=mac_dot and the next state is RESULT.
REQ-028 RESULT: res_valid=1, res_data held stable until res_valid&res_ready; then IDLE.
REQ-029 mac_bias SHALL be the latched bias from the CLEAR state through the end of RESULT.
REQ-030 abort in any non-IDLE state SHALL force IDLE next cycle with one mac_clr pulse; abort has priority over every other transition; no result is produced.
REQ-031 start outside IDLE SHALL be ignored with no err pulse.
REQ-032 The beat counter SHALL be LEN_W wide; len=2^LEN_W-1 completes without wrap.

Reset
REQ-033 On rst: state=IDLE, counters=0, latched len/bias=0, res_data=0, and busy, err, s_ready, mac_en, mac_clr, mac_read_en, res_valid=0.
REQ-034 rst asserted mid-job SHALL discard the job; the first job after reset starts with CLEAR, so no MAC residue carries over.

Structure
REQ-035 A shared package mac_pkg SHALL hold the FSM state encoding, MAC_LAT and LEN_W defaults, and DOT_W=16.
REQ-036 Single module, no sub-modules; FSM and counters are inline.

Verification
REQ-037 Test 1: len=4, bias=16'h0010, all s_data=64'h5555..., s_valid held high -> CLEAR 1 cycle, 4 mac_en cycles, MAC_LAT DRAIN cycles, res_valid with res_data=mac_dot sampled at the last DRAIN cycle.
REQ-038 Test 2: len=3, s_valid toggling 1-0-1-0-1 -> exactly 3 mac_en pulses, each aligned with s_valid high; DRAIN entered after the third.
REQ-039 Test 3: start with len=0 -> err high exactly one cycle, busy stays 0, no mac_clr.
REQ-040 Test 4: abort asserted after beat 2 of len=8 -> IDLE next cycle, one mac_clr pulse, no res_valid; next job completes normally.
REQ-041 Test 5: res_ready held low 5 cycles in RESULT -> res_valid and res_data stable; start pulsed during that time is ignored.
REQ-042 Test 6: rst asserted in ACCUM asynchronously -> all outputs 0 before the next clock edge; state IDLE.
